// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage PC bus between NPC/CP0 logic (master) and the fetch PC unit (slave).
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              pc_en;
  logic [ADDR_W-1:0] npc;
  logic              req;
  logic              eret_d;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc4_f;
  logic [ADDR_W-1:0] pc8_f;
  logic              kill_f;
  logic              adel_f;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output pc_en, npc, req, eret_d, epc,
    input  pc_f, pc4_f, pc8_f, kill_f, adel_f, fetch_cnt
  );

  modport slave (
    input  pc_en, npc, req, eret_d, epc,
    output pc_f, pc4_f, pc8_f, kill_f, adel_f, fetch_cnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC with exception/eret redirect, fetch-address error flag and fetch counter.
//   state  | meaning
//   S_RUN  | no eret waiting; PC follows npc / redirects
//   S_PEND | eret captured during a stall; pend_pc released on next pc_en
module pc_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC     = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IM_BASE     = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IM_LIMIT    = 32'h0000_6FFC,
  parameter bit                ERET_BYPASS = 1'b1,
  parameter int                CNT_W       = 32
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_unit_if.slave  fif
);

  typedef enum logic {S_RUN = 1'b0, S_PEND = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_reg, pc_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              kill;
  logic [ADDR_W-1:0] pc_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      pc_reg  <= RESET_VEC;
      pend_pc <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pc_reg  <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_reg;
    pend_pc_nxt = pend_pc;
    cnt_nxt     = cnt;
    kill        = 1'b0;
    if (fif.req) begin
      pc_nxt    = EXC_VEC;
      state_nxt = S_RUN;
    end else begin
      if (fif.pc_en) cnt_nxt = cnt + 1'b1;
      // Pending release outranks a new eret: the first captured epc wins.
      if (!ERET_BYPASS && state == S_PEND) begin
        if (fif.pc_en) begin
          pc_nxt    = pend_pc;
          state_nxt = S_RUN;
          kill      = ~reset;
        end
      end else if (!ERET_BYPASS && fif.eret_d) begin
        if (fif.pc_en) begin
          pc_nxt = fif.epc;
          kill   = ~reset;
        end else begin
          state_nxt   = S_PEND;
          pend_pc_nxt = fif.epc;
        end
      end else if (fif.pc_en) begin
        pc_nxt = fif.npc;
      end
    end
  end

  assign pc_cur = (ERET_BYPASS && fif.eret_d) ? fif.epc : pc_reg;

  assign fif.pc_f      = pc_cur;
  assign fif.pc4_f     = pc_cur + ADDR_W'(4);
  assign fif.pc8_f     = pc_cur + ADDR_W'(8);
  assign fif.kill_f    = kill;
  assign fif.adel_f    = (pc_cur[1:0] != 2'b00) || (pc_cur < IM_BASE) || (pc_cur > IM_LIMIT);
  assign fif.fetch_cnt = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: one bypass-mode and one registered-mode instance.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32), .CNT_W(32)) bi ();
  pc_fetch_unit_if #(.ADDR_W(32), .CNT_W(32)) ri ();

  pc_fetch_unit #(.ERET_BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .fif(bi));
  pc_fetch_unit #(.ERET_BYPASS(1'b0)) dut_r (.clk(clk), .reset(reset), .fif(ri));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bi.pc_en = 0; bi.npc = '0; bi.req = 0; bi.eret_d = 0; bi.epc = '0;
    ri.pc_en = 0; ri.npc = '0; ri.req = 0; ri.eret_d = 0; ri.epc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (bi.pc_f !== 32'h3000) begin failures++; $display("FAIL reset_b_pc got=%h exp=%h", bi.pc_f, 32'h3000); end
    checks++; if (ri.pc_f !== 32'h3000) begin failures++; $display("FAIL reset_r_pc got=%h exp=%h", ri.pc_f, 32'h3000); end
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL reset_kill got=%b exp=0", ri.kill_f); end
    checks++; if (ri.adel_f !== 1'b0) begin failures++; $display("FAIL reset_adel got=%b exp=0", ri.adel_f); end
    checks++; if (ri.fetch_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ri.fetch_cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    bi.pc_en = 1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h3000 + 32'(4 * i);
      checks++; if (bi.pc_f !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bi.pc_f, exp_pc); end
      checks++; if (bi.pc8_f !== exp_pc + 32'h8) begin failures++; $display("FAIL seq_pc8[%0d] got=%h exp=%h", i, bi.pc8_f, exp_pc + 32'h8); end
      checks++; if (bi.adel_f !== 1'b0) begin failures++; $display("FAIL seq_adel[%0d] got=%b exp=0", i, bi.adel_f); end
      if (i < 3) begin
        bi.npc = exp_pc + 32'h4;
        step();
      end
    end
    checks++; if (bi.fetch_cnt !== 32'd3) begin failures++; $display("FAIL seq_cnt got=%0d exp=3", bi.fetch_cnt); end
    bi.pc_en = 0;
  endtask

  task automatic test_req();
    ri.req = 1; ri.pc_en = 0; ri.eret_d = 1; ri.epc = 32'h3040;
    step();
    ri.req = 0; ri.eret_d = 0;
    checks++; if (ri.pc_f !== 32'h4180) begin failures++; $display("FAIL req_pc got=%h exp=%h", ri.pc_f, 32'h4180); end
    checks++; if (ri.fetch_cnt !== 32'd0) begin failures++; $display("FAIL req_cnt got=%0d exp=0", ri.fetch_cnt); end
    ri.pc_en = 1; ri.npc = 32'h4184;
    #1;
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL req_nopend_kill got=%b exp=0", ri.kill_f); end
    step();
    checks++; if (ri.pc_f !== 32'h4184) begin failures++; $display("FAIL req_nopend_pc got=%h exp=%h", ri.pc_f, 32'h4184); end
    checks++; if (ri.fetch_cnt !== 32'd1) begin failures++; $display("FAIL req_cnt2 got=%0d exp=1", ri.fetch_cnt); end
    ri.pc_en = 0;
  endtask

  task automatic test_bypass_eret();
    bi.eret_d = 1; bi.epc = 32'h3020;
    #1;
    checks++; if (bi.pc_f !== 32'h3020) begin failures++; $display("FAIL byp_pc got=%h exp=%h", bi.pc_f, 32'h3020); end
    checks++; if (bi.pc4_f !== 32'h3024) begin failures++; $display("FAIL byp_pc4 got=%h exp=%h", bi.pc4_f, 32'h3024); end
    checks++; if (bi.pc8_f !== 32'h3028) begin failures++; $display("FAIL byp_pc8 got=%h exp=%h", bi.pc8_f, 32'h3028); end
    checks++; if (bi.kill_f !== 1'b0) begin failures++; $display("FAIL byp_kill got=%b exp=0", bi.kill_f); end
    step();
    checks++; if (bi.pc_f !== 32'h3020) begin failures++; $display("FAIL byp_hold got=%h exp=%h", bi.pc_f, 32'h3020); end
    bi.pc_en = 1; bi.npc = 32'h3024;
    step();
    bi.eret_d = 0; bi.pc_en = 0;
    #1;
    checks++; if (bi.pc_f !== 32'h3024) begin failures++; $display("FAIL byp_after got=%h exp=%h", bi.pc_f, 32'h3024); end
    checks++; if (bi.fetch_cnt !== 32'd4) begin failures++; $display("FAIL byp_cnt got=%0d exp=4", bi.fetch_cnt); end
  endtask

  task automatic test_reg_eret();
    ri.eret_d = 1; ri.epc = 32'h3040; ri.pc_en = 0;
    #1;
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL reg_stall_kill got=%b exp=0", ri.kill_f); end
    step();
    checks++; if (ri.pc_f !== 32'h4184) begin failures++; $display("FAIL reg_hold1 got=%h exp=%h", ri.pc_f, 32'h4184); end
    ri.epc = 32'h3050;
    step();
    checks++; if (ri.pc_f !== 32'h4184) begin failures++; $display("FAIL reg_hold2 got=%h exp=%h", ri.pc_f, 32'h4184); end
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL reg_hold_kill got=%b exp=0", ri.kill_f); end
    ri.pc_en = 1; ri.npc = 32'h5000;
    #1;
    checks++; if (ri.kill_f !== 1'b1) begin failures++; $display("FAIL reg_release_kill got=%b exp=1", ri.kill_f); end
    step();
    checks++; if (ri.pc_f !== 32'h3040) begin failures++; $display("FAIL reg_release_pc got=%h exp=%h", ri.pc_f, 32'h3040); end
    checks++; if (ri.fetch_cnt !== 32'd2) begin failures++; $display("FAIL reg_cnt got=%0d exp=2", ri.fetch_cnt); end
    ri.eret_d = 0; ri.npc = 32'h3044;
    #1;
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL reg_post_kill got=%b exp=0", ri.kill_f); end
    step();
    checks++; if (ri.pc_f !== 32'h3044) begin failures++; $display("FAIL reg_post_pc got=%h exp=%h", ri.pc_f, 32'h3044); end
    ri.eret_d = 1; ri.epc = 32'h3060; ri.npc = 32'h5000;
    #1;
    checks++; if (ri.kill_f !== 1'b1) begin failures++; $display("FAIL reg_direct_kill got=%b exp=1", ri.kill_f); end
    step();
    ri.eret_d = 0;
    checks++; if (ri.pc_f !== 32'h3060) begin failures++; $display("FAIL reg_direct_pc got=%h exp=%h", ri.pc_f, 32'h3060); end
    checks++; if (ri.fetch_cnt !== 32'd4) begin failures++; $display("FAIL reg_direct_cnt got=%0d exp=4", ri.fetch_cnt); end
    ri.pc_en = 0;
  endtask

  task automatic test_adel();
    logic [31:0] vec_npc [5];
    logic        vec_adel [5];
    vec_npc[0] = 32'h3002; vec_adel[0] = 1;
    vec_npc[1] = 32'h2FFC; vec_adel[1] = 1;
    vec_npc[2] = 32'h7000; vec_adel[2] = 1;
    vec_npc[3] = 32'h6FFC; vec_adel[3] = 0;
    vec_npc[4] = 32'h3000; vec_adel[4] = 0;
    ri.pc_en = 1;
    for (int i = 0; i < 5; i++) begin
      ri.npc = vec_npc[i];
      step();
      checks++; if (ri.pc_f !== vec_npc[i]) begin failures++; $display("FAIL adel_pc[%0d] got=%h exp=%h", i, ri.pc_f, vec_npc[i]); end
      checks++; if (ri.adel_f !== vec_adel[i]) begin failures++; $display("FAIL adel[%0d] got=%b exp=%b", i, ri.adel_f, vec_adel[i]); end
    end
    ri.pc_en = 0;
    #1;
    checks++; if (ri.adel_f !== 1'b0) begin failures++; $display("FAIL adel_stall got=%b exp=0", ri.adel_f); end
  endtask

  task automatic test_reset_mid();
    ri.pc_en = 0; ri.eret_d = 1; ri.epc = 32'h3070;
    step();
    ri.eret_d = 0;
    reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (ri.pc_f !== 32'h3000) begin failures++; $display("FAIL rstmid_pc got=%h exp=%h", ri.pc_f, 32'h3000); end
    checks++; if (ri.fetch_cnt !== 32'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", ri.fetch_cnt); end
    ri.pc_en = 1; ri.npc = 32'h3100;
    #1;
    checks++; if (ri.kill_f !== 1'b0) begin failures++; $display("FAIL rstmid_kill got=%b exp=0", ri.kill_f); end
    step();
    checks++; if (ri.pc_f !== 32'h3100) begin failures++; $display("FAIL rstmid_next got=%h exp=%h", ri.pc_f, 32'h3100); end
    ri.pc_en = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_req();
    test_bypass_eret();
    test_reg_eret();
    test_adel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised fetch-stage program counter for the five-stage MIPS pipeline with precise exceptions. It keeps the fetch PC and applies redirects in this priority order: reset, exception request, eret, stall, next-PC. Eret handling is selectable between a zero-bubble combinational bypass and a registered redirect that uses a one-deep pending buffer and a kill pulse. It also flags fetch-address errors (AdEL) and counts accepted fetches. It sits between the NPC logic and the IM / IF-ID register.

Parameters:
ADDR_W, 32, PC width in bits (at least 16)
RESET_VEC, 32'h0000_3000, PC value after reset
EXC_VEC, 32'h0000_4180, exception handler entry
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)
ERET_BYPASS, 1, 1 = combinational epc bypass; 0 = registered redirect with pending buffer
CNT_W, 32, fetch counter width

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
pc_en  in  1  1 = advance PC this edge; 0 = stall (hold)
npc  in  ADDR_W  next PC from NPC logic
req  in  1  exception/interrupt request from CP0
eret_d  in  1  eret instruction present in D stage
epc  in  ADDR_W  EPC value from CP0
pc_f  out  ADDR_W  current fetch address
pc4_f  out  ADDR_W  pc_f + 4 (mod 2^ADDR_W)
pc8_f  out  ADDR_W  pc_f + 8 (mod 2^ADDR_W)
kill_f  out  1  IF-ID must load a bubble this edge (registered mode only)
adel_f  out  1  fetch address error on pc_f
fetch_cnt  out  CNT_W  number of accepted fetch advances

Behaviour:
- State: pc_reg, pend_vld, pend_pc, fetch_cnt.
- Reset sets pc_reg=RESET_VEC, pend_vld=0, pend_pc=0, fetch_cnt=0. Outputs after reset: pc_f=RESET_VEC, kill_f=0, adel_f per the rule below.
- Edge priority: reset > req > eret > pc_en > hold.
- req=1 (no reset): pc_reg<=EXC_VEC and pend_vld<=0. This applies regardless of pc_en and eret_d. fetch_cnt does not increment.
- Bypass mode (ERET_BYPASS=1):
  - While eret_d=1: pc_f=epc, pc4_f=epc+4, pc8_f=epc+8, all combinational in the same cycle.
  - Edge with eret_d=1 and pc_en=1: pc_reg<=npc. The NPC logic supplies epc+4 from pc4_f.
  - Edge with pc_en=0: hold. kill_f is always 0. pend_vld is never set.
- Registered mode (ERET_BYPASS=0): pc_f=pc_reg always.
  - eret_d=1 & pc_en=1 & !pend_vld: pc_reg<=epc, and kill_f=1 combinationally in that cycle.
  - eret_d=1 & pc_en=0: pend_vld<=1, pend_pc<=epc, pc_reg holds.
  - pend_vld=1 & pc_en=1: pc_reg<=pend_pc, pend_vld<=0, kill_f=1. eret_d is ignored in this case.
  - pend_vld=1 & pc_en=0: hold everything. pend_pc is not overwritten, because the first epc captured wins.
- Otherwise, pc_en=1 sets pc_reg<=npc and pc_en=0 holds.
- fetch_cnt increments by 1 (wrapping) on every edge with pc_en=1 and no reset or req. This includes eret redirect edges.
- adel_f=1 iff any of: pc_f[1:0]!=0, pc_f<IM_BASE, pc_f>IM_LIMIT. It is combinational on pc_f and independent of pc_en. The PC is not altered; CP0 raises req.
- Arithmetic is unsigned at ADDR_W bits and wraps silently.
- If reset arrives mid-operation (pending eret, stall), every register returns to its reset value on that edge.

Test Plan:
- Reset, then 3 edges with pc_en=1 and npc=pc4_f -> pc_f = 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt=3; adel_f=0.
- req=1 together with pc_en=0 and eret_d=1 -> next pc_f=0x4180; fetch_cnt unchanged; pend_vld cleared.
- Bypass mode, eret_d=1, epc=0x3020 -> same-cycle pc_f=0x3020 and pc8_f=0x3028. Edge with pc_en=1 and npc=0x3024 -> pc_f=0x3024.
- Registered mode, eret_d=1, epc=0x3040, pc_en=0 for 2 edges (epc changes to 0x3050 in between), then pc_en=1 -> pc_f holds, then becomes 0x3040; kill_f=1 only in the release cycle.
- npc=0x3002, then npc=0x2FFC, then npc=0x7000 -> adel_f=1 in each resulting cycle. npc=0x6FFC -> adel_f=0.
- Registered mode, eret_d stalled (pend_vld=1), then reset -> pc_f=0x3000, pend_vld=0, and the next pc_en edge loads npc.
